// File: rtl/me_search_ctrl.sv
// me_search_ctrl: full-search motion estimation controller that streams SAD rows through the compare tree and keeps the best match
module me_search_ctrl #(
  parameter int SAD_W = 18,
  parameter int LANES = 16,
  parameter int ROWS  = 16,
  parameter int MV_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  input  logic                   row_valid,
  output logic                   row_ready,
  input  logic [LANES*SAD_W-1:0] row_sad,
  output logic [LANES*SAD_W-1:0] cand_sad,
  output logic [SAD_W-1:0]       sad_min_pre,
  input  logic [SAD_W-1:0]       tree_sad_min,
  input  logic [MV_W-1:0]        tree_lane,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SAD_W-1:0]       best_sad,
  output logic [MV_W-1:0]        mv_x,
  output logic [MV_W-1:0]        mv_y
);
  typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_t;
  localparam logic [MV_W-1:0] LAST = MV_W'(ROWS - 1);
  state_t state;
  logic [MV_W-1:0] row_cnt;
  logic upd;
  logic [SAD_W-1:0] new_min;
  // row 0 always seeds the minimum; later rows need a strictly smaller SAD so ties keep the earlier row
  always_comb begin
    upd = (row_cnt == '0) || (tree_sad_min < sad_min_pre);
    new_min = upd ? tree_sad_min : sad_min_pre;
  end
  // search sequencer with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      row_ready   <= 1'b0;
      res_valid   <= 1'b0;
      best_sad    <= '0;
      mv_x        <= '0;
      mv_y        <= '0;
      cand_sad    <= '0;
      row_cnt     <= '0;
      sad_min_pre <= '1;
    end else begin
      case (state)
        IDLE: if (start) begin
          state       <= LOAD;
          busy        <= 1'b1;
          row_ready   <= 1'b1;
          row_cnt     <= '0;
          sad_min_pre <= '1;
        end
        LOAD: if (row_valid) begin
          cand_sad  <= row_sad;
          row_ready <= 1'b0;
          state     <= EVAL;
        end
        EVAL: begin
          if (upd) begin
            sad_min_pre <= tree_sad_min;
            mv_x        <= tree_lane;
            mv_y        <= row_cnt;
          end
          if (row_cnt == LAST) begin
            best_sad  <= new_min;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            row_cnt   <= row_cnt + 1'b1;
            row_ready <= 1'b1;
            state     <= LOAD;
          end
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          if (start) begin
            state       <= LOAD;
            row_ready   <= 1'b1;
            row_cnt     <= '0;
            sad_min_pre <= '1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_me_search_ctrl.sv
// tb_me_search_ctrl: scoreboard bench with a reference compare tree for me_search_ctrl
module tb_me_search_ctrl;
  localparam int W = 18;
  localparam int L = 16;
  localparam int R = 16;
  localparam int M = 4;
  typedef struct {
    logic [W-1:0] sad;
    logic [M-1:0] mx;
    logic [M-1:0] my;
  } res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, row_ready, res_valid;
  logic row_valid = 1'b0;
  logic res_ready = 1'b0;
  logic [L*W-1:0] row_sad = '0;
  logic [L*W-1:0] cand_sad;
  logic [W-1:0] sad_min_pre, tree_sad_min, best_sad;
  logic [M-1:0] tree_lane, mv_x, mv_y;
  logic [W-1:0] rows [R][L];
  res_t exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;

  me_search_ctrl #(.SAD_W(W), .LANES(L), .ROWS(R), .MV_W(M)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .row_valid(row_valid), .row_ready(row_ready), .row_sad(row_sad),
    .cand_sad(cand_sad), .sad_min_pre(sad_min_pre),
    .tree_sad_min(tree_sad_min), .tree_lane(tree_lane),
    .res_valid(res_valid), .res_ready(res_ready),
    .best_sad(best_sad), .mv_x(mv_x), .mv_y(mv_y)
  );

  always #5 clk = ~clk;

  // reference compare tree: minimum over lanes, lowest lane wins ties
  always_comb begin
    tree_sad_min = '1;
    tree_lane = '0;
    for (int i = L - 1; i >= 0; i--)
      if (cand_sad[i*W +: W] <= tree_sad_min) begin
        tree_sad_min = cand_sad[i*W +: W];
        tree_lane = M'(i);
      end
  end

  // count every row the controller accepts
  always @(posedge clk)
    if (!rst && row_valid && row_ready) n_acc <= n_acc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int mode);
    for (int r = 0; r < R; r++)
      for (int l = 0; l < L; l++)
        rows[r][l] = mode == 0 ? W'(1000) : mode == 1 ? '1 : W'($urandom_range(0, (1 << W) - 1));
  endtask

  task automatic push_exp();
    res_t e;
    logic [W:0] best = {1'b1, {W{1'b0}}};
    for (int r = 0; r < R; r++)
      for (int l = 0; l < L; l++)
        if ({1'b0, rows[r][l]} < best) begin
          best = {1'b0, rows[r][l]};
          e.mx = M'(l);
          e.my = M'(r);
        end
    e.sad = best[W-1:0];
    exp_q.push_back(e);
  endtask

  task automatic feed_row(input int r, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    row_valid = 1'b1;
    for (int l = 0; l < L; l++) row_sad[l*W +: W] = rows[r][l];
    while (!row_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("row_timeout", 0, 1);
    @(negedge clk);
    row_valid = gaps ? 1'b0 : row_valid;
  endtask

  task automatic run_block(input bit pre_started, input bit b2b, input bit gaps, input int hold, input bit noise);
    res_t e;
    int t = 0;
    int base = n_acc;
    push_exp();
    if (!pre_started) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    start = noise;
    for (int r = 0; r < R; r++) feed_row(r, gaps);
    row_valid = 1'b0;
    while (!res_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("res_timeout", 0, 1);
    e = exp_q[0];
    repeat (hold) begin
      check("hold_valid", 32'(res_valid), 1);
      check("hold_sad", 32'(best_sad), 32'(e.sad));
      check("hold_mv", {mv_x, mv_y}, {e.mx, e.my});
      @(negedge clk);
    end
    start = b2b;
    res_ready = 1'b1;
    e = exp_q.pop_front();
    check("best_sad", 32'(best_sad), 32'(e.sad));
    check("mv_x", 32'(mv_x), 32'(e.mx));
    check("mv_y", 32'(mv_y), 32'(e.my));
    check("rows_used", 32'(n_acc - base), R);
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    check("after_valid", 32'(res_valid), 0);
    check("after_busy", 32'(busy), 32'(b2b));
    if (b2b) begin
      check("b2b_ready", 32'(row_ready), 1);
      check("b2b_min", 32'(sad_min_pre), 32'({W{1'b1}}));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(row_ready), 0);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_min", 32'(sad_min_pre), 32'({W{1'b1}}));
    check("rst_res", {best_sad, mv_x, mv_y}, 0);
    check("rst_cand", 32'(|cand_sad), 0);
    rst = 1'b0;
    @(negedge clk);
    fill(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < 5; r++) feed_row(r, 1'b0);
    row_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("mid_busy", 32'(busy), 0);
    check("mid_ready", 32'(row_ready), 0);
    check("mid_valid", 32'(res_valid), 0);
    check("mid_min", 32'(sad_min_pre), 32'({W{1'b1}}));
    repeat (3) @(negedge clk);
    check("mid_idle_valid", 32'(res_valid | busy), 0);
    fill(0);
    rows[9][5] = W'(37);
    run_block(1'b0, 1'b0, 1'b0, 0, 1'b0);
    fill(0);
    rows[2][3] = W'(50);
    rows[11][7] = W'(50);
    run_block(1'b0, 1'b0, 1'b0, 2, 1'b0);
    fill(0);
    rows[15][15] = W'(1);
    rows[7][0] = W'(2);
    run_block(1'b0, 1'b0, 1'b0, 0, 1'b0);
    fill(2);
    run_block(1'b0, 1'b0, 1'b1, 10, 1'b1);
    fill(2);
    run_block(1'b0, 1'b1, 1'b0, 1, 1'b0);
    fill(2);
    run_block(1'b1, 1'b0, 1'b1, 0, 1'b0);
    fill(1);
    run_block(1'b0, 1'b0, 1'b0, 0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
